// File: rtl/axi4_burst_writer.sv
// axi4_burst_writer: splits a start command plus a data stream into
// INCR AXI4 write bursts with a bounded number of open B responses.
module axi4_burst_writer #(
  parameter int id_width_p    = 4,
  parameter int addr_width_p  = 32,
  parameter int data_width_p  = 64,
  parameter int burst_len_p   = 16,
  parameter int outstanding_p = 2,
  parameter int id_p          = 0,
  localparam int mosi_w_lp =
    2*(id_width_p+addr_width_p+31)
    + data_width_p + data_width_p/8 + 5,
  localparam int miso_w_lp =
    2*id_width_p + data_width_p + 12
) (
  input  logic                    clk_i,
  input  logic                    reset_n_i,
  input  logic                    start_v_i,
  input  logic [addr_width_p-1:0] start_addr_i,
  input  logic [31:0]             start_beats_i,
  output logic                    ready_o,
  input  logic                    data_v_i,
  input  logic [data_width_p-1:0] data_i,
  output logic                    data_ready_o,
  output logic                    done_o,
  output logic                    error_o,
  output logic [mosi_w_lp-1:0]    m_axi4_o,
  input  logic [miso_w_lp-1:0]    m_axi4_i
);

  localparam int bytes_lp = data_width_p/8;
  localparam int size_lp  = $clog2(bytes_lp);

  typedef struct packed {
    logic [id_width_p-1:0]     awid;
    logic [addr_width_p-1:0]   awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awlock;
    logic [3:0]                awcache;
    logic [2:0]                awprot;
    logic [3:0]                awqos;
    logic [3:0]                awregion;
    logic                      awuser;
    logic                      awvalid;
    logic [data_width_p-1:0]   wdata;
    logic [bytes_lp-1:0]       wstrb;
    logic                      wlast;
    logic                      wuser;
    logic                      wvalid;
    logic                      bready;
    logic [id_width_p-1:0]     arid;
    logic [addr_width_p-1:0]   araddr;
    logic [7:0]                arlen;
    logic [2:0]                arsize;
    logic [1:0]                arburst;
    logic                      arlock;
    logic [3:0]                arcache;
    logic [2:0]                arprot;
    logic [3:0]                arqos;
    logic [3:0]                arregion;
    logic                      aruser;
    logic                      arvalid;
    logic                      rready;
  } mosi_s;

  typedef struct packed {
    logic                      awready;
    logic                      wready;
    logic [id_width_p-1:0]     bid;
    logic [1:0]                bresp;
    logic                      buser;
    logic                      bvalid;
    logic                      arready;
    logic [id_width_p-1:0]     rid;
    logic [data_width_p-1:0]   rdata;
    logic [1:0]                rresp;
    logic                      rlast;
    logic                      ruser;
    logic                      rvalid;
  } miso_s;

  typedef enum logic [2:0] {
    IDLE, AW, W, DRAIN, DONE
  } state_e;

  mosi_s mosi;
  miso_s miso;

  assign miso     = m_axi4_i;
  assign m_axi4_o = mosi;

  state_e                  state_r, state_n;
  logic [addr_width_p-1:0] addr_r, addr_n;
  logic [31:0]             rem_r, rem_n;
  logic [7:0]              awlen_r, awlen_n;
  logic [7:0]              cur_len_r, cur_len_n;
  logic [7:0]              beat_r, beat_n;
  logic [3:0]              out_r, out_n;
  logic                    awvalid_r, awvalid_n;
  logic                    error_r, error_n;

  logic        start_hs, aw_hs, w_hs, b_hs, b_dec;
  logic        wlast;
  logic [8:0]  len;
  logic [31:0] rem_after;

  function automatic logic [7:0] len_m1(
    input logic [31:0] rem
  );
    if (rem >= 32'(burst_len_p))
      return 8'(burst_len_p - 1);
    return 8'(rem - 32'd1);
  endfunction

  assign start_hs  = start_v_i & (state_r == IDLE);
  assign aw_hs     = awvalid_r & miso.awready;
  assign w_hs      = (state_r == W) & data_v_i
                   & miso.wready;
  assign wlast     = (state_r == W)
                   & (beat_r == cur_len_r);
  assign b_hs      = miso.bvalid;
  assign b_dec     = b_hs & (out_r != 4'd0);
  assign len       = {1'b0, awlen_r} + 9'd1;
  assign rem_after = rem_r - 32'(len);

  always_comb begin
    state_n   = state_r;
    addr_n    = addr_r;
    rem_n     = rem_r;
    awlen_n   = awlen_r;
    cur_len_n = cur_len_r;
    beat_n    = beat_r;
    error_n   = error_r;

    unique case ({aw_hs, b_dec})
      2'b10:   out_n = out_r + 4'd1;
      2'b01:   out_n = out_r - 4'd1;
      default: out_n = out_r;
    endcase

    if (start_hs)
      error_n = 1'b0;
    else if (b_hs && miso.bresp != 2'b00)
      error_n = 1'b1;

    unique case (state_r)
      IDLE: if (start_hs) begin
        addr_n  = start_addr_i;
        rem_n   = start_beats_i;
        awlen_n = len_m1(start_beats_i);
        state_n = (start_beats_i == 32'd0)
                ? DONE : AW;
      end
      AW: if (aw_hs) begin
        addr_n    = addr_r
                  + (addr_width_p'(len) << size_lp);
        rem_n     = rem_after;
        awlen_n   = len_m1(rem_after);
        cur_len_n = awlen_r;
        beat_n    = 8'd0;
        state_n   = W;
      end
      W: if (w_hs) begin
        beat_n = beat_r + 8'd1;
        if (wlast)
          state_n = (rem_r != 32'd0) ? AW : DRAIN;
      end
      DRAIN: if (out_n == 4'd0)
        state_n = DONE;
      DONE: state_n = IDLE;
    endcase

    // held once raised: out_r cannot grow until awready
    awvalid_n = (state_n == AW)
              && (out_n < 4'(outstanding_p));
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r   <= IDLE;
      addr_r    <= '0;
      rem_r     <= '0;
      awlen_r   <= '0;
      cur_len_r <= '0;
      beat_r    <= '0;
      out_r     <= '0;
      awvalid_r <= 1'b0;
      error_r   <= 1'b0;
    end else begin
      state_r   <= state_n;
      addr_r    <= addr_n;
      rem_r     <= rem_n;
      awlen_r   <= awlen_n;
      cur_len_r <= cur_len_n;
      beat_r    <= beat_n;
      out_r     <= out_n;
      awvalid_r <= awvalid_n;
      error_r   <= error_n;
    end
  end

  always_comb begin
    mosi         = '0;
    mosi.awid    = id_width_p'(id_p);
    mosi.awaddr  = addr_r;
    mosi.awlen   = awlen_r;
    mosi.awsize  = 3'(size_lp);
    mosi.awburst = 2'b01;
    mosi.awcache = 4'b0011;
    mosi.awvalid = awvalid_r;
    mosi.wdata   = data_i;
    mosi.wstrb   = '1;
    mosi.wlast   = wlast;
    mosi.wvalid  = (state_r == W) & data_v_i;
    mosi.bready  = 1'b1;
    mosi.rready  = 1'b1;
  end

  assign ready_o      = (state_r == IDLE);
  assign done_o       = (state_r == DONE);
  assign error_o      = error_r;
  assign data_ready_o = (state_r == W) & miso.wready;

  logic unused_miso;
  assign unused_miso = ^{miso.bid, miso.buser,
    miso.arready, miso.rid, miso.rdata,
    miso.rresp, miso.rlast, miso.ruser,
    miso.rvalid};

  b_needs_open_burst: assert property (
    @(posedge clk_i) disable iff (!reset_n_i)
    b_hs |-> (out_r != 4'd0));

endmodule

// File: tb/tb_axi4_burst_writer.sv
// tb_axi4_burst_writer: directed vector table plus hand sequences
// against a small always-on AXI4 slave model.
module tb_axi4_burst_writer;

  localparam int ID  = 4;
  localparam int AW  = 32;
  localparam int DW  = 512;
  localparam int BL  = 16;
  localparam int OS  = 2;
  localparam int IDP = 5;

  typedef struct packed {
    logic [ID-1:0]   awid;
    logic [AW-1:0]   awaddr;
    logic [7:0]      awlen;
    logic [2:0]      awsize;
    logic [1:0]      awburst;
    logic            awlock;
    logic [3:0]      awcache;
    logic [2:0]      awprot;
    logic [3:0]      awqos;
    logic [3:0]      awregion;
    logic            awuser;
    logic            awvalid;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic            wlast;
    logic            wuser;
    logic            wvalid;
    logic            bready;
    logic [ID-1:0]   arid;
    logic [AW-1:0]   araddr;
    logic [7:0]      arlen;
    logic [2:0]      arsize;
    logic [1:0]      arburst;
    logic            arlock;
    logic [3:0]      arcache;
    logic [2:0]      arprot;
    logic [3:0]      arqos;
    logic [3:0]      arregion;
    logic            aruser;
    logic            arvalid;
    logic            rready;
  } mosi_t;

  typedef struct packed {
    logic            awready;
    logic            wready;
    logic [ID-1:0]   bid;
    logic [1:0]      bresp;
    logic            buser;
    logic            bvalid;
    logic            arready;
    logic [ID-1:0]   rid;
    logic [DW-1:0]   rdata;
    logic [1:0]      rresp;
    logic            rlast;
    logic            ruser;
    logic            rvalid;
  } miso_t;

  typedef struct {
    logic [31:0] addr;
    int          beats;
    bit          rnd;
    int          err_b;
    int          exp_aw;
    bit          exp_err;
  } vec_t;

  logic          clk_i = 1'b0;
  logic          reset_n_i = 1'b1;
  logic          start_v_i = 1'b0;
  logic [AW-1:0] start_addr_i = '0;
  logic [31:0]   start_beats_i = '0;
  logic          ready_o;
  logic          data_v_i = 1'b0;
  logic [DW-1:0] data_i = '0;
  logic          data_ready_o;
  logic          done_o;
  logic          error_o;
  mosi_t         mosi;
  miso_t         miso = '0;

  axi4_burst_writer #(
    .id_width_p    (ID),
    .addr_width_p  (AW),
    .data_width_p  (DW),
    .burst_len_p   (BL),
    .outstanding_p (OS),
    .id_p          (IDP)
  ) dut (
    .clk_i         (clk_i),
    .reset_n_i     (reset_n_i),
    .start_v_i     (start_v_i),
    .start_addr_i  (start_addr_i),
    .start_beats_i (start_beats_i),
    .ready_o       (ready_o),
    .data_v_i      (data_v_i),
    .data_i        (data_i),
    .data_ready_o  (data_ready_o),
    .done_o        (done_o),
    .error_o       (error_o),
    .m_axi4_o      (mosi),
    .m_axi4_i      (miso)
  );

  always #5 clk_i = ~clk_i;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [31:0] xf_addr = '0;
  int xf_beats = 0;
  bit rnd = 1'b0;
  bit b_hold = 1'b0;
  int err_b = -1;
  int aw_cnt = 0;
  int beat_cnt = 0;
  int len_sum = 0;
  int b_cnt = 0;
  int pend = 0;
  int done_cnt = 0;
  int b_first_cyc = -1;
  int b_last_cyc = -1;
  int aw_cyc[$];
  bit aw_stall = 1'b0;
  mosi_t aw_prev;

  always @(posedge clk_i) cyc <= cyc + 1;

  function automatic logic [DW-1:0] pat(input int i);
    return {16{32'(i) ^ 32'hA5C3_0000}};
  endfunction

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] want);
    n_run++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, want);
    end
  endtask

  // slave + data source, driven just after each rising edge
  always @(posedge clk_i) begin
    #1;
    miso.awready = rnd ? ($urandom_range(0, 2) != 0)
                       : 1'b1;
    miso.wready  = rnd ? ($urandom_range(0, 2) != 0)
                       : 1'b1;
    data_v_i = (beat_cnt < xf_beats)
             && !(rnd && $urandom_range(0, 3) == 0);
    data_i = pat(beat_cnt);
    miso.bvalid = !b_hold && (pend > 0);
    miso.bresp  = (b_cnt == err_b) ? 2'b10 : 2'b00;
    miso.bid    = ID'(IDP);
  end

  always @(negedge clk_i) begin
    int  rem;
    int  l;
    bit  exp_last;
    if (!reset_n_i) begin
      aw_stall = 1'b0;
    end else begin
      if (aw_stall) begin
        chk("aw_hold_valid", 64'(mosi.awvalid), 64'd1);
        chk("aw_hold_fields",
            64'({mosi.awaddr, mosi.awlen}),
            64'({aw_prev.awaddr, aw_prev.awlen}));
      end
      if (mosi.awvalid && miso.awready) begin
        rem = xf_beats - BL * aw_cnt;
        l = (rem > BL) ? BL : rem;
        chk("awaddr", 64'(mosi.awaddr),
            64'(xf_addr + 32'(aw_cnt * BL * (DW/8))));
        chk("awlen", 64'(mosi.awlen), 64'(l - 1));
        chk("aw_const",
            64'({mosi.awid, mosi.awsize, mosi.awburst,
                 mosi.awlock, mosi.awcache, mosi.awprot,
                 mosi.awqos, mosi.awregion}),
            64'({4'h5, 3'd6, 2'b01, 1'b0, 4'b0011,
                 3'd0, 4'd0, 4'd0}));
        len_sum += int'(mosi.awlen) + 1;
        aw_cyc.push_back(cyc);
        aw_cnt++;
      end
      aw_stall = mosi.awvalid && !miso.awready;
      aw_prev = mosi;
      if (mosi.wvalid && miso.wready) begin
        exp_last = ((beat_cnt + 1) % BL == 0)
                || (beat_cnt + 1 == xf_beats);
        chk("wdata", 64'(mosi.wdata == pat(beat_cnt)),
            64'd1);
        chk("wstrb", 64'(&mosi.wstrb), 64'd1);
        chk("wlast", 64'(mosi.wlast), 64'(exp_last));
        chk("data_ready", 64'(data_ready_o), 64'd1);
        beat_cnt++;
        if (mosi.wlast) pend++;
      end
      if (miso.bvalid && mosi.bready) begin
        pend--;
        b_cnt++;
        if (b_first_cyc < 0) b_first_cyc = cyc;
        b_last_cyc = cyc;
      end
      if (done_o) done_cnt++;
    end
  end

  task automatic setup(input logic [31:0] a,
                       input int n, input bit r,
                       input bit h, input int e);
    xf_addr = a;
    xf_beats = n;
    rnd = r;
    b_hold = h;
    err_b = e;
    aw_cnt = 0;
    beat_cnt = 0;
    len_sum = 0;
    b_cnt = 0;
    done_cnt = 0;
    b_first_cyc = -1;
    b_last_cyc = -1;
    aw_cyc.delete();
  endtask

  task automatic start_xfer(output int sc);
    @(posedge clk_i);
    #1;
    start_v_i = 1'b1;
    start_addr_i = xf_addr;
    start_beats_i = 32'(xf_beats);
    @(negedge clk_i);
    chk("start_ready", 64'(ready_o), 64'd1);
    sc = cyc;
    @(posedge clk_i);
    #1;
    start_v_i = 1'b0;
    @(negedge clk_i);
    chk("err_clear", 64'(error_o), 64'd0);
    chk("aw_latency", 64'(mosi.awvalid),
        64'(xf_beats != 0));
  endtask

  task automatic wait_done(output int dc);
    int t = 0;
    while (done_o !== 1'b1 && t < 3000) begin
      @(negedge clk_i);
      t++;
    end
    if (done_o === 1'b1) begin
      dc = cyc;
    end else begin
      dc = -1;
      chk("done_timeout", 64'd0, 64'd1);
    end
  endtask

  task automatic run_vec(input vec_t v);
    int sc;
    int dc;
    setup(v.addr, v.beats, v.rnd, 1'b0, v.err_b);
    start_xfer(sc);
    wait_done(dc);
    if (dc >= 0) begin
      chk("error_at_done", 64'(error_o), 64'(v.exp_err));
      chk("done_cycle", 64'(dc),
          64'((v.beats == 0) ? sc + 1 : b_last_cyc + 1));
      chk("ready_at_done", 64'(ready_o), 64'd0);
      @(negedge clk_i);
      chk("ready_after", 64'(ready_o), 64'd1);
      chk("error_hold", 64'(error_o), 64'(v.exp_err));
      repeat (2) @(negedge clk_i);
      chk("aw_count", 64'(aw_cnt), 64'(v.exp_aw));
      chk("beat_count", 64'(beat_cnt), 64'(v.beats));
      chk("len_sum", 64'(len_sum), 64'(v.beats));
      chk("done_once", 64'(done_cnt), 64'd1);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[7];
    int sc;
    int dc;
    int t;
    tbl[0] = '{32'h0000_1000, 40, 1'b0, -1, 3, 1'b0};
    tbl[1] = '{32'h0000_2000, 48, 1'b0,  1, 3, 1'b1};
    tbl[2] = '{32'h0000_4000, 100, 1'b1, -1, 7, 1'b0};
    tbl[3] = '{32'h0000_0000, 0, 1'b0, -1, 0, 1'b0};
    tbl[4] = '{32'h0000_0400, 1, 1'b0, -1, 1, 1'b0};
    tbl[5] = '{32'h0000_8000, 16, 1'b1, -1, 1, 1'b0};
    tbl[6] = '{32'h0001_0000, 17, 1'b0,  1, 2, 1'b1};

    #1 reset_n_i = 1'b0;
    #1;
    chk("rst_ready", 64'(ready_o), 64'd1);
    chk("rst_awvalid", 64'(mosi.awvalid), 64'd0);
    chk("rst_wvalid", 64'(mosi.wvalid), 64'd0);
    chk("rst_done", 64'(done_o), 64'd0);
    chk("rst_error", 64'(error_o), 64'd0);
    chk("rst_dready", 64'(data_ready_o), 64'd0);
    repeat (3) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // B responses withheld: only two bursts may open
    setup(32'h0002_0000, 64, 1'b0, 1'b1, -1);
    start_xfer(sc);
    repeat (60) @(negedge clk_i);
    chk("os_aw_count", 64'(aw_cnt), 64'd2);
    chk("os_gated", 64'(mosi.awvalid), 64'd0);
    chk("os_no_b", 64'(b_cnt), 64'd0);
    b_hold = 1'b0;
    wait_done(dc);
    if (aw_cyc.size() > 2)
      chk("os_third_aw", 64'(aw_cyc[2]),
          64'(b_first_cyc + 1));
    else
      chk("os_third_aw", 64'(aw_cyc.size()), 64'd3);
    chk("os_aw_total", 64'(aw_cnt), 64'd4);
    repeat (2) @(negedge clk_i);

    setup(32'h0000_3000, 16, 1'b0, 1'b0, -1);
    start_xfer(sc);
    t = 0;
    while (beat_cnt < 5 && t < 100) begin
      @(negedge clk_i);
      t++;
    end
    chk("mid_beat_reached", 64'(beat_cnt >= 5), 64'd1);
    #2 reset_n_i = 1'b0;
    #1;
    chk("mid_rst_awvalid", 64'(mosi.awvalid), 64'd0);
    chk("mid_rst_wvalid", 64'(mosi.wvalid), 64'd0);
    chk("mid_rst_ready", 64'(ready_o), 64'd1);
    pend = 0;
    repeat (2) @(negedge clk_i);
    reset_n_i = 1'b1;
    @(negedge clk_i);
    run_vec('{32'h0000_5000, 20, 1'b0, -1, 2, 1'b0});

    $display("[TB] %0d tests run, %0d failed",
             n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/axi4_burst_writer.md
# axi4_burst_writer

AXI4 write-burst master that turns a start command plus a valid/ready data stream into INCR write bursts on one slave slot of the AXI4 mux. One instance sits upstream of each mux slot that carries bulk writes (e.g. DMA or host-copy engines). It splits a transfer into bursts, keeps a bounded number of bursts awaiting B responses, reports completion, and flags any non-OKAY response. The read channels are tied off.

## Interface
- id_width_p, "inv": AXI ID width; must match the mux.
- addr_width_p, "inv": AXI address width.
- data_width_p, "inv": AXI data width in bits, a power of two between 32 and 1024.
- burst_len_p, 16: maximum beats per burst, 1..256.
  - burst_len_p*data_width_p/8 must not exceed 4096.
- outstanding_p, 2: maximum bursts awaiting a B response, 1..15.
- id_p, 0: constant AWID value.
- clk_i input 1: clock.
- reset_n_i input 1: asynchronous, active-low reset.
- start_v_i input 1: start-command valid.
- start_addr_i input addr_width_p: byte address of the first beat.
  - Must be aligned to burst_len_p*data_width_p/8.
- start_beats_i input 32: total beats; 0 is legal.
- ready_o output 1: idle, so a start is accepted.
- data_v_i input 1: write-data valid.
- data_i input data_width_p: write data.
- data_ready_o output 1: write data consumed this cycle.
- done_o output 1: one-cycle pulse when the transfer is complete.
- error_o output 1: sticky flag; set if any BRESP != 2'b00.
- m_axi4_o output `bsg_axi4_mosi_bus_width(1,id_width_p,addr_width_p,data_width_p)`: packed mosi bus in the team bus-struct field order.
- m_axi4_i input `bsg_axi4_miso_bus_width(1,id_width_p,addr_width_p,data_width_p)`: packed miso bus.

## Operation
- States:
  - IDLE: ready_o=1.
  - AW: awvalid=1.
  - W: beats stream.
  - DRAIN: wait for outstanding B responses.
  - DONE: done_o=1 for one cycle.
- Start handshake: start_v_i&ready_o latches the address and remaining beats and clears error_o.
  - Beats = 0: go directly to DONE.
  - Otherwise go to AW.
- Burst length: min(remaining, burst_len_p).
- AW fields:
  - awaddr = current address.
  - awlen = burst length - 1.
  - awsize = log2(data_width_p/8).
  - awburst = 2'b01.
  - awcache = 4'b0011.
  - awid = id_p.
  - awlock, awprot, awqos and awregion are 0.
- AW gating: awvalid is asserted only while outstanding < outstanding_p. AW holds its fields stable until awready.
- AW handshake:
  - outstanding increments.
  - Address advances by the burst length * bytes per beat.
  - Remaining decrements by the burst length.
  - Move to W.
- W: wvalid=data_v_i, wdata=data_i, wstrb all ones, data_ready_o=wready.
  - wlast is high on the final beat of the burst.
  - On the wlast handshake: go to AW if remaining>0, otherwise to DRAIN.
- B channel: bready is always 1. Each bvalid decrements outstanding, and a nonzero bresp sets error_o.
- Simultaneous AW handshake and B handshake in one cycle: outstanding is unchanged.
- DRAIN → DONE when outstanding = 0, including in the same cycle as the final B handshake.
- DONE → IDLE.
- Read channels: arvalid=0, rready=1, all other AR fields 0. R beats are ignored.
- start_v_i while not in IDLE is ignored.
- A B response with outstanding = 0 is a protocol error: assertion in simulation; the counter saturates at 0.

## Timing
- Reset values (asynchronous):
  - state IDLE, ready_o=1.
  - awvalid, wvalid, done_o, error_o, data_ready_o = 0.
  - Counters cleared.
  - Reset mid-transfer drops all valids immediately; in-flight AXI transactions are abandoned.
- Start latency: start accepted at cycle 0, awvalid high at cycle 1.
- AW handshake at cycle N: first wvalid-eligible cycle is N+1.
- Beat throughput: one beat per cycle when data_v_i and wready are both high.
- Burst to burst: last wlast handshake at cycle M gives awvalid at M+1, provided outstanding < outstanding_p.
- Completion: final B handshake at cycle K gives done_o at K+1 and ready_o at K+2.
- Zero beats: start at cycle 0, done_o at cycle 1.
- awvalid and all AW fields are registered. wvalid and data_ready_o are combinational from data_v_i and wready.

## Test plan
- Basic burst split, data_width_p=512, burst_len_p=16, start 0x1000, 40 beats, always-ready slave:
  - AWs at 0x1000/0x1400/0x1800 with awlen 15/15/7.
  - wlast on beats 16, 32 and 40.
  - done_o once; error_o=0.
- Zero-length start → done_o at cycle 1, no AW/W activity.
- Outstanding limit, outstanding_p=2, B responses withheld, 64 beats:
  - Exactly 2 AWs issue; the third appears only the cycle after the first B.
- Error response on the second of three bursts, bresp=2'b10:
  - error_o stays high through done_o and clears on the next start.
- Random wready/awready/data_v_i stalls, 100 beats:
  - Data order is preserved.
  - AW fields are stable while stalled.
  - Beat count equals the sum of (awlen+1).
- Reset: drop reset_n_i mid-burst (beat 5 of 16) → awvalid/wvalid=0 asynchronously and ready_o=1; a new transfer then completes normally.
